// File: rtl/spi_rx_ip_top.sv
// 4-wire SPI mode-0 receiver: oversampled, MSB-first bytes tagged with dc into a FWFT FIFO.
// Latency: rx_valid SYNC_STAGES+1 clk after the 8th scl rise is sampled; full FIFO drops bytes unless popped that cycle.
module spi_rx_ip_top #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cs,
    input  logic                          dc,
    input  logic                          scl,
    input  logic                          sda,
    input  logic                          rx_ready,
    output logic [7:0]                    rx_data,
    output logic                          rx_dc,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clr_status
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_dly_q, scl_dly_d;
    logic                   cs_dly_q, cs_dly_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [8:0]             mem_q [FIFO_DEPTH];
    logic [8:0]             mem_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q, frame_err_d;

    logic       cs_s, dc_s, scl_s, sda_s;
    logic       scl_rise, cs_rise;
    logic       push_req, push, pop, full, ovf_set, frame_set;
    logic [7:0] push_dat;

    always_comb begin
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs};
        dc_sync_d  = {dc_sync_q[SYNC_STAGES-2:0], dc};
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        cs_s       = cs_sync_q[SYNC_STAGES-1];
        dc_s       = dc_sync_q[SYNC_STAGES-1];
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_dly_d  = scl_s;
        cs_dly_d   = cs_s;
        scl_rise   = scl_s & ~scl_dly_q;
        cs_rise    = cs_s & ~cs_dly_q;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        push_dat  = {shift_q[6:0], sda_s};
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 3'd0;
                if (!cs_s) state_d = ST_SHIFT;
            end
            default: begin
                if (scl_rise) begin
                    shift_d   = push_dat;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    push_req  = (bit_cnt_q == 3'd7);
                end
                // A byte completing in the same cycle as cs release is not a framing error
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                    frame_set = (bit_cnt_q != 3'd0) && !(scl_rise && bit_cnt_q == 3'd7);
                end
            end
        endcase
    end

    always_comb begin
        full     = (count_q == CW'(FIFO_DEPTH));
        pop      = (count_q != '0) && rx_ready;
        push     = push_req && (!full || pop);
        ovf_set  = push_req && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {dc_s, push_dat};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        overflow_d  = (overflow_q & ~clr_status) | ovf_set;
        frame_err_d = (frame_err_q & ~clr_status) | frame_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_q   <= '1;
            dc_sync_q   <= '0;
            scl_sync_q  <= '0;
            sda_sync_q  <= '0;
            scl_dly_q   <= 1'b0;
            cs_dly_q    <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 9'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            dc_sync_q   <= dc_sync_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_dly_q   <= scl_dly_d;
            cs_dly_q    <= cs_dly_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        rx_valid   = (count_q != '0);
        rx_data    = rx_valid ? mem_q[rd_ptr_q][7:0] : 8'd0;
        rx_dc      = rx_valid ? mem_q[rd_ptr_q][8] : 1'b0;
        fifo_count = count_q;
        overflow   = overflow_q;
        frame_err  = frame_err_q;
    end
endmodule

// File: tb/tb_spi_rx_ip_top.sv
// Directed bench for spi_rx_ip_top; inputs driven and outputs sampled on the falling clk edge.
module tb_spi_rx_ip_top;
    logic       clk = 1'b0;
    logic       reset, cs, dc, scl, sda, rx_ready, clr_status;
    logic [7:0] rx_data;
    logic       rx_dc, rx_valid, overflow, frame_err;
    logic [2:0] fifo_count;

    int vectors = 0;
    int miscompares = 0;
    logic lat_pre, lat_post;

    spi_rx_ip_top #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .dc(dc), .scl(scl), .sda(sda),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid),
        .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err),
        .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sends the top n bits of b, scl period 10 clk; records rx_valid around the last rise.
    task automatic send_bits(input logic [7:0] b, input int n, input bit pop_last);
        for (int i = 0; i < n; i++) begin
            sda = b[7-i];
            repeat (5) @(negedge clk);
            scl = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (i == n - 1 && k == 2) begin
                    lat_pre = rx_valid;
                    if (pop_last) rx_ready = 1'b1;
                end
                if (i == n - 1 && k == 3) begin
                    lat_post = rx_valid;
                    rx_ready = 1'b0;
                end
            end
            scl = 1'b0;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic frame_begin(input logic d);
        dc = d;
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cs = 1'b1; dc = 1'b0; scl = 1'b0; sda = 1'b0;
        rx_ready = 1'b0; clr_status = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h exp 00", rx_data); end
        vectors++; if (rx_dc !== 1'b0) begin miscompares++; $display("FAIL reset_dc got %b exp 0", rx_dc); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        vectors++; if ({overflow, frame_err} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b exp 00", {overflow, frame_err}); end
    endtask

    task automatic test_command();
        frame_begin(1'b0);
        send_bits(8'h11, 8, 1'b0);
        frame_end();
        vectors++; if (lat_pre !== 1'b0) begin miscompares++; $display("FAIL cmd_latency_early got %b exp 0", lat_pre); end
        vectors++; if (lat_post !== 1'b1) begin miscompares++; $display("FAIL cmd_latency_edge3 got %b exp 1", lat_post); end
        vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL cmd_valid got %b exp 1", rx_valid); end
        vectors++; if (rx_data !== 8'h11) begin miscompares++; $display("FAIL cmd_data got %h exp 11", rx_data); end
        vectors++; if (rx_dc !== 1'b0) begin miscompares++; $display("FAIL cmd_dc got %b exp 0", rx_dc); end
        vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL cmd_count got %0d exp 1", fifo_count); end
        vectors++; if ({overflow, frame_err} !== 2'b00) begin miscompares++; $display("FAIL cmd_flags got %b exp 00", {overflow, frame_err}); end
        pop_one();
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL cmd_pop_count got %0d exp 0", fifo_count); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h29; exp_b[1] = 8'hA5; exp_b[2] = 8'h3C;
        frame_begin(1'b1);
        for (int i = 0; i < 3; i++) send_bits(exp_b[i], 8, 1'b0);
        frame_end();
        vectors++; if (fifo_count !== 3'd3) begin miscompares++; $display("FAIL burst_count got %0d exp 3", fifo_count); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if ({rx_valid, rx_dc, rx_data} !== {2'b11, exp_b[i]}) begin miscompares++; $display("FAIL burst_entry%0d got v%b dc%b %h exp v1 dc1 %h", i, rx_valid, rx_dc, rx_data, exp_b[i]); end
            pop_one();
        end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL burst_empty got %b exp 0", rx_valid); end
    endtask

    task automatic test_overflow();
        frame_begin(1'b0);
        for (int i = 1; i <= 5; i++) send_bits(8'(i), 8, 1'b0);
        frame_end();
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL ovf_count got %0d exp 4", fifo_count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        vectors++; if (rx_data !== 8'h01) begin miscompares++; $display("FAIL ovf_head got %h exp 01", rx_data); end
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_push_pop();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h02; exp_b[1] = 8'h03; exp_b[2] = 8'h04; exp_b[3] = 8'h77;
        frame_begin(1'b0);
        send_bits(8'h77, 8, 1'b1);
        frame_end();
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL pp_count got %0d exp 4", fifo_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL pp_overflow got %b exp 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (rx_data !== exp_b[i]) begin miscompares++; $display("FAIL pp_entry%0d got %h exp %h", i, rx_data, exp_b[i]); end
            pop_one();
        end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL pp_empty got %b exp 0", rx_valid); end
    endtask

    task automatic test_frame_err();
        frame_begin(1'b0);
        send_bits(8'hFF, 5, 1'b0);
        frame_end();
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL ferr_flag got %b exp 1", frame_err); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL ferr_count got %0d exp 0", fifo_count); end
        frame_begin(1'b1);
        send_bits(8'h42, 8, 1'b0);
        frame_end();
        vectors++; if ({fifo_count, rx_dc, rx_data} !== {3'd1, 1'b1, 8'h42}) begin miscompares++; $display("FAIL ferr_next got cnt%0d dc%b %h exp cnt1 dc1 42", fifo_count, rx_dc, rx_data); end
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL ferr_clear got %b exp 0", frame_err); end
        pop_one();
    endtask

    task automatic test_reset_mid();
        frame_begin(1'b0);
        send_bits(8'hAA, 8, 1'b0);
        send_bits(8'hBB, 8, 1'b0);
        vectors++; if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL rmid_prefill got %0d exp 2", fifo_count); end
        send_bits(8'hF0, 4, 1'b0);
        reset = 1'b1;
        cs = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if ({rx_valid, rx_dc, rx_data, fifo_count, overflow, frame_err} !== 14'd0) begin miscompares++; $display("FAIL rmid_outputs got v%b dc%b %h cnt%0d ovf%b ferr%b exp all 0", rx_valid, rx_dc, rx_data, fifo_count, overflow, frame_err); end
        frame_begin(1'b0);
        send_bits(8'h5A, 8, 1'b0);
        frame_end();
        vectors++; if ({fifo_count, rx_data, frame_err} !== {3'd1, 8'h5A, 1'b0}) begin miscompares++; $display("FAIL rmid_next got cnt%0d %h ferr%b exp cnt1 5a ferr0", fifo_count, rx_data, frame_err); end
        pop_one();
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_empty got %b exp 0", rx_valid); end
    endtask

    initial begin
        test_reset();
        test_command();
        test_burst();
        test_overflow();
        test_push_pop();
        test_frame_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
